// File: rtl/dla_clock_cross_handshake_src_if.sv
// -----------------------------------------------------------------------------
// dla_clock_cross_handshake_src_if
//
// Bundle for the source half of a 2-phase req/ack bus crossing.
//   i_src_valid / i_src_data / o_src_ready : valid/ready word intake (clk_src)
//   o_src_busy                             : a transfer is awaiting its ack
//   o_src_protocol_error                   : sticky, ack toggled with no request
//   o_xfer_req_toggle / o_xfer_data        : request toggle and held data bus
//                                            toward the destination domain
//   i_xfer_ack_toggle                      : ack toggle from the destination
//                                            domain (asynchronous to clk_src)
//
// Modports:
//   master : the crossing source block (drives the o_* signals)
//   slave  : its environment (word producer plus destination half)
// -----------------------------------------------------------------------------
interface dla_clock_cross_handshake_src_if #(
  parameter int WIDTH = 32
);
  logic             i_src_valid;
  logic [WIDTH-1:0] i_src_data;
  logic             o_src_ready;
  logic             o_src_busy;
  logic             o_src_protocol_error;
  logic             o_xfer_req_toggle;
  logic [WIDTH-1:0] o_xfer_data;
  logic             i_xfer_ack_toggle;

  modport master (
    input  i_src_valid,
    input  i_src_data,
    input  i_xfer_ack_toggle,
    output o_src_ready,
    output o_src_busy,
    output o_src_protocol_error,
    output o_xfer_req_toggle,
    output o_xfer_data
  );

  modport slave (
    output i_src_valid,
    output i_src_data,
    output i_xfer_ack_toggle,
    input  o_src_ready,
    input  o_src_busy,
    input  o_src_protocol_error,
    input  o_xfer_req_toggle,
    input  o_xfer_data
  );
endinterface

// File: rtl/dla_clock_cross_handshake_src.sv
// -----------------------------------------------------------------------------
// dla_clock_cross_handshake_src
//
// Source-side half of a toggle-based (2-phase) req/ack bus crossing.
// A word accepted on the valid/ready intake is captured onto a held bus and
// announced by flipping the request toggle. The block then waits until the
// synchronized ack toggle matches the request toggle before taking the next
// word, so the held bus is constant whenever the destination may sample it.
//
// Ports:
//   clk_src            : source clock
//   i_src_async_resetn : async active-low reset, released synchronously to
//                        clk_src by the system reset sequence
//   bus (master)       : intake, status, request/data and ack signals, see
//                        dla_clock_cross_handshake_src_if
//
// Parameters:
//   WIDTH                : data width, >= 1
//   METASTABILITY_STAGES : ack synchronizer depth, >= 2
// -----------------------------------------------------------------------------
module dla_clock_cross_handshake_src #(
  parameter int WIDTH                = 32,
  parameter int METASTABILITY_STAGES = 3
) (
  input  logic                            clk_src,
  input  logic                            i_src_async_resetn,
  dla_clock_cross_handshake_src_if.master bus
);

  // Elaboration-time parameter checks.
  if (WIDTH < 1) begin : g_width_check
    $error("dla_clock_cross_handshake_src: WIDTH must be >= 1");
  end
  if (METASTABILITY_STAGES < 2) begin : g_stages_check
    $error("dla_clock_cross_handshake_src: METASTABILITY_STAGES must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_IDLE     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  state_t                          state_q;
  state_t                          state_d;
  logic [METASTABILITY_STAGES-1:0] ack_sync_q;
  logic                            ack_s;
  logic                            req_q;
  logic [WIDTH-1:0]                data_q;
  logic                            error_q;
  logic                            accept;

  // ---------------------------------------------------------------------------
  // Ack synchronizer: bit 0 is the only flop that sees the asynchronous input.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, which is what makes this a chain.
  always_ff @(posedge clk_src or negedge i_src_async_resetn) begin
    if (!i_src_async_resetn) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[METASTABILITY_STAGES-2:0], bus.i_xfer_ack_toggle};
    end
  end

  assign ack_s = ack_sync_q[METASTABILITY_STAGES-1];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_src or negedge i_src_async_resetn) begin
    if (!i_src_async_resetn) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // A word is taken only from IDLE; valid during WAIT_ACK is ignored.
  assign accept = (state_q == ST_IDLE) && bus.i_src_valid;

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment before the case keeps this purely
  // combinational; any path that left state_d unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:     state_d = ST_IDLE;
      ST_IDLE:     if (accept) state_d = ST_WAIT_ACK;
      // Equal toggles mean the destination has consumed the current word.
      ST_WAIT_ACK: if (ack_s == req_q) state_d = ST_IDLE;
      default:     state_d = ST_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode, from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.o_src_ready = 1'b0;
    bus.o_src_busy  = 1'b0;
    unique case (state_q)
      ST_IDLE:     bus.o_src_ready = 1'b1;
      ST_WAIT_ACK: bus.o_src_busy  = 1'b1;
      default:     ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Held request toggle and data bus. Both move only on an accepting edge, so
  // they are frozen through WAIT_ACK and IDLE while the destination samples.
  // ---------------------------------------------------------------------------
  // NOTE: the data register is reset on purpose: the destination half may
  // observe the bus straight out of reset, so it must come up at a known 0.
  always_ff @(posedge clk_src or negedge i_src_async_resetn) begin
    if (!i_src_async_resetn) begin
      req_q  <= 1'b0;
      data_q <= '0;
    end else if (accept) begin
      req_q  <= ~req_q;
      data_q <= bus.i_src_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky protocol error: in IDLE nothing is outstanding, so the synchronized
  // ack must already equal the request toggle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_src or negedge i_src_async_resetn) begin
    if (!i_src_async_resetn) begin
      error_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && (ack_s != req_q)) begin
      error_q <= 1'b1;
    end
  end

  assign bus.o_xfer_req_toggle    = req_q;
  assign bus.o_xfer_data          = data_q;
  assign bus.o_src_protocol_error = error_q;

endmodule
